serial_adder_fsm: RTL and testbench

- Parametrised bit-serial N-bit adder, successor to the single-bit full adder.
- Each clock it processes one bit pair, LSB first, through one full-adder cell, carrying through a registered carry.
- Start/busy/done handshake; the result is held until the next operation.
- Area-minimal arithmetic for control paths where latency of WIDTH cycles is acceptable.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_fsm_fa_cell.sv | 15 +
 rtl/serial_adder_fsm.sv | 141 ++++++++++++++
 tb/tb_serial_adder_fsm.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and legal WIDTH range.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/serial_adder_fsm_fa_cell.sv
// Single-bit full adder cell; the per-cycle arithmetic of the serial adder.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module fa_cell (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell plus a registered carry.
// Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH; one op per WIDTH+1 cycles.
// Backpressure: start is ignored while busy; SERIAL_ADDER_SUB_EN adds a Sub input selecting A-B.
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);
    import serial_adder_pkg::*;

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder_fsm: WIDTH must be within 1..64");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_bit;
    logic             w_carry;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic [WIDTH-1:0] w_res_nxt;

    // Subtraction is A + ~B + 1, so the carry register is forced high and Cin is ignored.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = Sub ? ~B : B;
    assign w_c_load = Sub | Cin;
`else
    assign w_b_load = B;
    assign w_c_load = Cin;
`endif

    assign w_last = (r_cnt == LAST_CNT);

    fa_cell u_fa (
        .A    (r_a_sh[0]),
        .B    (r_b_sh[0]),
        .Cin  (r_c),
        .Sum  (w_bit),
        .Cout (w_carry)
    );

    // Result shift: the new sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH steps.
    always_comb begin
        w_res_nxt            = r_res >> 1;
        w_res_nxt[WIDTH-1]   = w_bit;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; DONE accepts a new start just like IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: load operands on accept, shift one bit per RUN cycle, publish result on the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_res  <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            Sum    <= '0;
            Cout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh <= A;
            r_b_sh <= w_b_load;
            r_res  <= '0;
            r_c    <= w_c_load;
            r_cnt  <= '0;
        end else if (r_state == RUN) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_res  <= w_res_nxt;
            r_c    <= w_carry;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
                Sum  <= w_res_nxt;
                Cout <= w_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Self-checking bench for serial_adder_fsm: WIDTH=1 and WIDTH=8 instances, table vectors plus corner sequences.
// Latency: checks done timing, busy length and back-to-back spacing.
// Backpressure: checks that start during RUN is ignored.
module tb_serial_adder_fsm;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub1, sub8;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    serial_adder_fsm #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub(sub1),
`endif
        .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1)
    );

    serial_adder_fsm #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub(sub8),
`endif
        .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8)
    );

    typedef struct {
        logic a, b, cin, sum, cout;
    } vec1_t;

    typedef struct {
        logic [7:0] a, b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec8_t;

    vec1_t t1[8];
    vec8_t t8[7];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start one op on the WIDTH=8 instance and wait (bounded) for done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output int lat, output int bc);
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = 0; bc = 0;
        while (!done8 && lat < 20) begin
            if (busy8) bc++;
            tick();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, t_first, n_done;

        t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        t1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        t1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        t1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        t1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        t1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        t1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        t1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        t8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        t8[1] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
        t8[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        t8[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        t8[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        t8[5] = '{8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0};
        t8[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        rst = 1'b1;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub1 = 1'b0; sub8 = 1'b0;
`endif
        tick(); tick();

        // Reset state
        check("rst busy8", busy8, 0);
        check("rst done8", done8, 0);
        check("rst sum8",  sum8,  0);
        check("rst cout8", cout8, 0);
        check("rst busy1", busy1, 0);
        check("rst sum1",  sum1,  0);
        rst = 1'b0;
        tick();

        // WIDTH=1: exhaustive full-adder table
        for (int i = 0; i < 8; i++) begin
            a1 = t1[i].a; b1 = t1[i].b; cin1 = t1[i].cin; start1 = 1'b1;
            tick();
            start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            check($sformatf("w1[%0d] busy", i), busy1, 1);
            check($sformatf("w1[%0d] early done", i), done1, 0);
            tick();
            check($sformatf("w1[%0d] done", i), done1, 1);
            check($sformatf("w1[%0d] sum", i),  sum1,  t1[i].sum);
            check($sformatf("w1[%0d] cout", i), cout1, t1[i].cout);
            tick();
            check($sformatf("w1[%0d] done pulse", i), done1, 0);
        end

        // WIDTH=8: table of additions
        for (int i = 0; i < 7; i++) begin
            run8(t8[i].a, t8[i].b, t8[i].cin, lat, bc);
            check($sformatf("w8[%0d] latency", i), lat, 8);
            check($sformatf("w8[%0d] busy cycles", i), bc, 8);
            check($sformatf("w8[%0d] sum", i),  sum8,  t8[i].sum);
            check($sformatf("w8[%0d] cout", i), cout8, t8[i].cout);
            tick();
            check($sformatf("w8[%0d] done pulse", i), done8, 0);
            check($sformatf("w8[%0d] sum hold", i), sum8, t8[i].sum);
        end

        // start re-pulsed mid-RUN is ignored; previous Sum (8'h46) held until DONE
        a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        for (int k = 0; k < 3; k++) begin tick(); lat++; end
        check("mid busy", busy8, 1);
        check("mid sum held", sum8, 8'h46);
        start8 = 1'b1; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        tick(); lat++;
        start8 = 1'b0;
        check("mid busy after restart", busy8, 1);
        check("mid sum held 2", sum8, 8'h46);
        while (!done8 && lat < 20) begin tick(); lat++; end
        check("mid latency", lat, 8);
        check("mid sum", sum8, 8'h97);
        check("mid cout", cout8, 0);
        tick();

        // Back-to-back with start held through DONE
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        a8 = 8'h80; b8 = 8'h80;
        lat = 0;
        while (!done8 && lat < 20) begin tick(); lat++; end
        t_first = cyc;
        check("b2b first latency", lat, 8);
        check("b2b first sum", sum8, 8'h02);
        check("b2b first cout", cout8, 0);
        tick();
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        check("b2b reaccept busy", busy8, 1);
        check("b2b reaccept done", done8, 0);
        lat = 0;
        while (!done8 && lat < 20) begin tick(); lat++; end
        check("b2b spacing", cyc - t_first, 9);
        check("b2b second sum", sum8, 8'h00);
        check("b2b second cout", cout8, 1);
        tick();

        // Reset mid-RUN at cnt=4
        run8(8'h12, 8'h34, 1'b0, lat, bc);
        check("pre-rst sum", sum8, 8'h46);
        tick();
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("pre-rst busy", busy8, 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort busy", busy8, 0);
        check("abort done", done8, 0);
        check("abort sum",  sum8,  0);
        check("abort cout", cout8, 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done8 || busy8) n_done++;
        end
        check("abort no done/busy", n_done, 0);
        run8(8'h3C, 8'h5A, 1'b1, lat, bc);
        check("post-rst latency", lat, 8);
        check("post-rst sum", sum8, 8'h97);
        check("post-rst cout", cout8, 0);
        tick();

`ifdef SERIAL_ADDER_SUB_EN
        // Subtraction
        sub8 = 1'b1;
        run8(8'd5, 8'd7, 1'b0, lat, bc);
        check("sub 5-7 sum", sum8, 8'hFE);
        check("sub 5-7 cout", cout8, 0);
        tick();
        run8(8'd7, 8'd5, 1'b0, lat, bc);
        check("sub 7-5 sum", sum8, 8'h02);
        check("sub 7-5 cout", cout8, 1);
        sub8 = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
